// File: rtl/acc_chain_reader_if.sv
// acc_chain_reader_if
//   Groups the input beat stream and the result stream of acc_chain_reader.
//   Parameters:
//     n    - width of data words and of the product
//     LENW - width of the beat count
//   Input stream (producer -> reader):
//     in_data, in_valid, in_last
//     in_ready (reader -> producer)
//   Result stream (reader -> consumer):
//     out_data, out_count, out_ovf, out_valid
//     out_ready (consumer -> reader)
//   Modports:
//     slave  - reader side
//     master - environment side
interface acc_chain_reader_if #(
  parameter int unsigned n    = 8,
  parameter int unsigned LENW = 8
);
  logic [n-1:0]    in_data;
  logic            in_valid;
  logic            in_last;
  logic            in_ready;
  logic [n-1:0]    out_data;
  logic [LENW-1:0] out_count;
  logic            out_ovf;
  logic            out_valid;
  logic            out_ready;

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_count, out_ovf, out_valid
  );

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_count, out_ovf, out_valid
  );
endinterface

// File: rtl/acc_chain_reader.sv
// acc_chain_reader
//   Folds a framed stream of n-bit words multiplicatively into an accumulator
//   that is seeded with 1. At end of frame it presents the product, the
//   saturating beat count and a sticky overflow flag. It holds them until the
//   result handshake completes.
//   Ports:
//     clk   - rising-edge clock
//     reset - asynchronous active-low reset
//     bus   - acc_chain_reader_if.slave, carrying the beat and result streams
//   Build option:
//     ACC_CHAIN_READER_SAT_EN - when defined, the accumulator saturates to
//     all-ones once overflow is seen. When undefined, it wraps to the low
//     n bits.
module acc_chain_reader #(
  parameter int unsigned n    = 8,
  parameter int unsigned LENW = 8
) (
  input  logic                clk,
  input  logic                reset,
  acc_chain_reader_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [n-1:0]    acc_q, acc_d;
  logic [LENW-1:0] cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic [n-1:0]    res_data_q, res_data_d;
  logic [LENW-1:0] res_cnt_q, res_cnt_d;
  logic            res_ovf_q, res_ovf_d;
  logic            out_valid_q, out_valid_d;

  logic [2*n-1:0]  prod;
  logic [n-1:0]    acc_nxt;
  logic [LENW-1:0] cnt_nxt;
  logic            ovf_nxt;
  logic            in_ready;
  logic            accept;

  assign in_ready = (state_q != HOLD);
  assign accept   = bus.in_valid && in_ready;

  // These are the per-beat update values, including the current beat.
  always_comb begin
    prod    = {{n{1'b0}}, acc_q} * {{n{1'b0}}, bus.in_data};
    ovf_nxt = ovf_q | (prod[2*n-1:n] != '0);
`ifdef ACC_CHAIN_READER_SAT_EN
    // A zero product overrides saturation, so a zero word still forces 0.
    if (prod == '0) begin
      acc_nxt = '0;
    end else if (ovf_nxt) begin
      acc_nxt = '1;
    end else begin
      acc_nxt = prod[n-1:0];
    end
`else
    acc_nxt = prod[n-1:0];
`endif
    cnt_nxt = (cnt_q == '1) ? cnt_q : cnt_q + LENW'(1);
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    res_data_d  = res_data_q;
    res_cnt_d   = res_cnt_q;
    res_ovf_d   = res_ovf_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          if (bus.in_last) begin
            res_data_d  = acc_nxt;
            res_cnt_d   = cnt_nxt;
            res_ovf_d   = ovf_nxt;
            out_valid_d = 1'b1;
            acc_d       = n'(1);
            cnt_d       = '0;
            ovf_d       = 1'b0;
            state_d     = HOLD;
          end else begin
            acc_d   = acc_nxt;
            cnt_d   = cnt_nxt;
            ovf_d   = ovf_nxt;
            state_d = ACCUM;
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      acc_q       <= n'(1);
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      res_data_q  <= n'(1);
      res_cnt_q   <= '0;
      res_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      res_data_q  <= res_data_d;
      res_cnt_q   <= res_cnt_d;
      res_ovf_q   <= res_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = res_data_q;
  assign bus.out_count = res_cnt_q;
  assign bus.out_ovf   = res_ovf_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_acc_chain_reader.sv
// tb_acc_chain_reader
//   Directed bench for acc_chain_reader. Instance A uses n=8 and LENW=8.
//   Instance B uses n=8 and LENW=2 to exercise beat-count saturation.
//   Inputs are driven and outputs sampled on the falling clock edge.
module tb_acc_chain_reader;

  logic clk;
  logic reset;
  int unsigned vectors;
  int unsigned miscompares;

  acc_chain_reader_if #(.n(8), .LENW(8)) bus_a ();
  acc_chain_reader_if #(.n(8), .LENW(2)) bus_b ();

  acc_chain_reader #(.n(8), .LENW(8)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  acc_chain_reader #(.n(8), .LENW(2)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Wait, with a bound, for in_ready. Then present one beat across one rising edge.
  task automatic beat_a(input logic [7:0] d, input logic l);
    int unsigned budget;
    budget = 0;
    while (bus_a.in_ready !== 1'b1 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 20) check("in_ready_timeout", 32'(bus_a.in_ready), 32'd1);
    bus_a.in_data  = d;
    bus_a.in_last  = l;
    bus_a.in_valid = 1'b1;
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    bus_a.in_last  = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [7:0] d, input logic [7:0] c,
                              input logic o);
    check({tag, "_valid"}, 32'(bus_a.out_valid), 32'd1);
    check({tag, "_data"},  32'(bus_a.out_data),  32'(d));
    check({tag, "_count"}, 32'(bus_a.out_count), 32'(c));
    check({tag, "_ovf"},   32'(bus_a.out_ovf),   32'(o));
    check({tag, "_inrdy"}, 32'(bus_a.in_ready),  32'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset          = 1'b0;
    bus_a.in_data  = '0;
    bus_a.in_valid = 1'b0;
    bus_a.in_last  = 1'b0;
    bus_a.out_ready = 1'b1;
    bus_b.in_data  = '0;
    bus_b.in_valid = 1'b0;
    bus_b.in_last  = 1'b0;
    bus_b.out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_data",  32'(bus_a.out_data),  32'd1);
    check("rst_count", 32'(bus_a.out_count), 32'd0);
    check("rst_ovf",   32'(bus_a.out_ovf),   32'd0);
    check("rst_valid", 32'(bus_a.out_valid), 32'd0);
    check("rst_inrdy", 32'(bus_a.in_ready),  32'd1);
    reset = 1'b1;
    @(negedge clk);

    // Basic frame: 2*3*4 = 24
    beat_a(8'd2, 1'b0);
    beat_a(8'd3, 1'b0);
    beat_a(8'd4, 1'b1);
    check_result("basic", 8'd24, 8'd3, 1'b0);
    @(negedge clk);
    check("basic_valid_drop", 32'(bus_a.out_valid), 32'd0);
    check("basic_inrdy_back", 32'(bus_a.in_ready),  32'd1);
    check("basic_data_kept",  32'(bus_a.out_data),  32'd24);

    // Overflow: 16*16 = 256
    beat_a(8'd16, 1'b0);
    beat_a(8'd16, 1'b1);
`ifdef ACC_CHAIN_READER_SAT_EN
    check_result("ovf", 8'd255, 8'd2, 1'b1);
`else
    check_result("ovf", 8'd0, 8'd2, 1'b1);
`endif
    @(negedge clk);

    // Zero after overflow: the product is 0 and the flag stays set
    beat_a(8'd16, 1'b0);
    beat_a(8'd16, 1'b0);
    beat_a(8'd0,  1'b1);
    check_result("zero_ovf", 8'd0, 8'd3, 1'b1);
    @(negedge clk);

    // Zero word alone is not an overflow
    beat_a(8'd5, 1'b0);
    beat_a(8'd0, 1'b0);
    beat_a(8'd7, 1'b1);
    check_result("zero", 8'd0, 8'd3, 1'b0);
    @(negedge clk);

    // Backpressure
    bus_a.out_ready = 1'b0;
    beat_a(8'd5, 1'b1);
    for (int i = 0; i < 6; i++) begin
      check("bp_valid", 32'(bus_a.out_valid), 32'd1);
      check("bp_data",  32'(bus_a.out_data),  32'd5);
      check("bp_inrdy", 32'(bus_a.in_ready),  32'd0);
      // A beat offered while in HOLD must not be accepted
      bus_a.in_data  = 8'd99;
      bus_a.in_valid = 1'b1;
      bus_a.in_last  = 1'b1;
      @(negedge clk);
    end
    bus_a.in_valid = 1'b0;
    bus_a.in_last  = 1'b0;
    check("bp_data_end", 32'(bus_a.out_data), 32'd5);
    bus_a.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release", 32'(bus_a.out_valid), 32'd0);
    beat_a(8'd3, 1'b1);
    check_result("reseed", 8'd3, 8'd1, 1'b0);
    @(negedge clk);

    // Throttled input: 7*1*2 = 14
    beat_a(8'd7, 1'b0);
    repeat (3) @(negedge clk);
    beat_a(8'd1, 1'b0);
    repeat (3) @(negedge clk);
    beat_a(8'd2, 1'b1);
    check_result("throttle", 8'd14, 8'd3, 1'b0);
    @(negedge clk);

    // Reset mid-frame
    beat_a(8'd9, 1'b0);
    beat_a(8'd9, 1'b0);
    reset = 1'b0;
    #1;
    check("midrst_valid", 32'(bus_a.out_valid), 32'd0);
    check("midrst_data",  32'(bus_a.out_data),  32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    beat_a(8'd2, 1'b1);
    check_result("midrst", 8'd2, 8'd1, 1'b0);
    @(negedge clk);

    // Count saturation on the LENW=2 instance: 5 beats of 1
    for (int i = 0; i < 5; i++) begin
      check("sat_inrdy", 32'(bus_b.in_ready), 32'd1);
      bus_b.in_data  = 8'd1;
      bus_b.in_last  = (i == 4);
      bus_b.in_valid = 1'b1;
      @(negedge clk);
    end
    bus_b.in_valid = 1'b0;
    bus_b.in_last  = 1'b0;
    check("sat_valid", 32'(bus_b.out_valid), 32'd1);
    check("sat_count", 32'(bus_b.out_count), 32'd3);
    check("sat_data",  32'(bus_b.out_data),  32'd1);
    check("sat_ovf",   32'(bus_b.out_ovf),   32'd0);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
